regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised MIPS general-purpose register file with a built-in initialisation sequencer, a hardwired zero register, write-to-read bypass, and a per-register scoreboard of pending writes. It sits between decode (two read ports plus a destination reservation port) and writeback (one write port) in the pipelined core. It replaces the fixed 32×32 file, which has no reset, no bypass and no hazard tracking.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries
- SP_IDX, 29, index of the stack pointer
- SP_INIT, 32'h00008000, initial value of entry SP_IDX
- ZERO_REG, 1, 1 = entry 0 reads as 0, ignores writes and ignores reservations

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr_a  in  ADDR_W  read port A index
- rd_addr_b  in  ADDR_W  read port B index
- rd_data_a  out  DATA_W  port A data, combinational
- rd_data_b  out  DATA_W  port B data, combinational
- rd_busy_a  out  1  port A register has a pending write
- rd_busy_b  out  1  port B register has a pending write
- wr_en  in  1  writeback enable
- wr_addr  in  ADDR_W  writeback index
- wr_data  in  DATA_W  writeback data
- rsv_en  in  1  mark rsv_addr as pending (issued instruction's destination)
- rsv_addr  in  ADDR_W  index to reserve
- flush  in  1  clear all pending bits (pipeline squash)
- ready  out  1  initialisation complete; ports are live

## Operation
- States: INIT and RUN. reset_n low forces INIT, init_cnt=0, ready=0 and all busy bits=0 asynchronously. The array is not reset asynchronously; INIT overwrites it.
- INIT: each edge writes entry init_cnt with SP_INIT if init_cnt==SP_IDX, else with init_cnt zero-extended to DATA_W. Then init_cnt increments. The edge that writes entry DEPTH-1 moves to RUN and sets ready=1.
- In INIT, wr_en, rsv_en and flush are ignored. rd_data_* and rd_busy_* output 0.
- RUN, write: on an edge with wr_en=1, array[wr_addr] <= wr_data and busy[wr_addr] <= 0. When ZERO_REG=1 and wr_addr==0, nothing is written.
- RUN, read: rd_data_x = array[rd_addr_x], with two overrides:
  - If wr_en=1 and wr_addr==rd_addr_x, wr_data is bypassed through.
  - Entry 0 always reads 0 when ZERO_REG=1; the zero rule beats the bypass.
- RUN, reserve: on an edge with rsv_en=1, busy[rsv_addr] <= 1. Ignored for entry 0 when ZERO_REG=1.
- Same-edge rsv_en and wr_en to the same index: the set wins, so busy stays 1 (the new producer is pending). The data write still happens.
- rd_busy_x = busy[rd_addr_x] & ~(wr_en & wr_addr==rd_addr_x). This is consistent with the data bypass: a write landing this cycle is not a hazard.
- flush=1 clears every busy bit on the edge. flush beats a same-edge rsv_en, which is dropped. A same-edge wr_en still writes the array.
- Reset in RUN or mid-INIT restarts INIT from entry 0. Any in-progress writes are lost.

## Timing
- Reset values: ready=0, rd_busy_a=rd_busy_b=0, rd_data_a=rd_data_b=0.
- Init latency is exactly DEPTH rising edges after reset_n deasserts; ready is high after edge DEPTH (edge 32 for defaults).
- Read latency is 0: combinational from address, array, busy and write-port inputs.
- Write and reserve take effect on the next rising edge. The same-cycle view is provided only through the bypass.
- reset_n deassertion is assumed synchronised externally. ready must not glitch high during INIT.

## Test plan
- Reset, then count edges; read all entries once ready=1 -> ready rises after edge 32; entry k reads k, entry 29 reads 0x00008000, entry 0 reads 0.
- In RUN, wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr_a=5 in the same cycle -> rd_data_a=0xDEADBEEF before the edge; after the edge with wr_en=0 it still reads 0xDEADBEEF.
- Write 0x12345678 to entry 0; read entry 0 with and without a concurrent write -> always 0; rsv_en to entry 0 leaves rd_busy=0.
- rsv_en to 7; next cycle read 7 -> rd_busy=1; wr_en to 7 in that same cycle -> rd_busy=0 that cycle and 0 after the edge. Same-edge rsv_en and wr_en on 9 -> busy[9]=1 afterwards.
- Reserve 3, 4 and 6, then flush=1 together with rsv_en=8 -> after the edge, busy bits for 3, 4, 6 and 8 all read 0.
- Write 0xAAAA to 10, then pulse reset_n low mid-RUN -> ready=0 and busy=0 immediately; after 32 edges entry 10 reads 10; writes issued during INIT have no effect.

Source files
------------

// File: rtl/regfile_sb.sv
// MIPS GPR file: self-initialising after reset, hardwired r0, write-to-read
// bypass, and a per-register pending-write scoreboard for decode hazard checks.
module regfile_sb #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_INIT  = 'h00008000,
  parameter bit                ZERO_REG = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic              ready
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SP_A  = ADDR_W'(SP_IDX);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   init_cnt_q;
  logic                ready_q;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   init_val;
  logic                wr_ok, rsv_ok;

  assign wr_ok    = wr_en  && !(ZERO_REG && wr_addr  == '0);
  assign rsv_ok   = rsv_en && !(ZERO_REG && rsv_addr == '0);
  assign init_val = (init_cnt_q == SP_A) ? SP_INIT : DATA_W'(init_cnt_q);

  // Set beats same-edge clear (new producer pending); flush beats everything.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[wr_addr]  = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
    if (flush)  busy_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == '1) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN:   busy_q <= busy_d;
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Storage has no reset; the INIT sweep overwrites every entry.
  always_ff @(posedge clock) begin
    if (state_q == S_INIT)
      mem_q[init_cnt_q] <= init_val;
    else if (wr_ok)
      mem_q[wr_addr] <= wr_data;
  end

  logic [1:0][ADDR_W-1:0] ra;
  logic [1:0][DATA_W-1:0] rdat;
  logic [1:0]             rbsy;

  assign ra = {rd_addr_b, rd_addr_a};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit, zero;
    assign hit     = wr_en && (wr_addr == ra[p]);
    assign zero    = ZERO_REG && (ra[p] == '0);
    assign rdat[p] = (!ready_q || zero) ? '0 : (hit ? wr_data : mem_q[ra[p]]);
    assign rbsy[p] = ready_q & busy_q[ra[p]] & ~hit;
  end

  assign rd_data_a = rdat[0];
  assign rd_data_b = rdat[1];
  assign rd_busy_a = rbsy[0];
  assign rd_busy_b = rbsy[1];
  assign ready     = ready_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed plan steps plus a randomized
// phase checked against an array/bitmask model of the register file.
module tb_regfile_sb;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data;
  logic        rd_busy_a, rd_busy_b, wr_en, rsv_en, flush, ready;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mdl [32];
  logic [31:0] mbusy;

  regfile_sb dut (
    .clock(clock), .reset_n(reset_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .ready(ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return mdl[a];
  endfunction

  function automatic logic ref_busy(input logic [4:0] a);
    return mbusy[a] && !(wr_en && wr_addr == a);
  endfunction

  task automatic model_init();
    for (int k = 0; k < 32; k++) mdl[k] = (k == 29) ? 32'h00008000 : 32'(k);
    mbusy = '0;
  endtask

  task automatic idle();
    wr_en = 0; rsv_en = 0; flush = 0;
    wr_addr = 0; rsv_addr = 0; wr_data = 0;
  endtask

  // One RUN-mode clock: fold the pending inputs into the model, then step.
  task automatic cyc();
    if (wr_en) begin
      if (wr_addr != 0) mdl[wr_addr] = wr_data;
      mbusy[wr_addr] = 1'b0;
    end
    if (rsv_en && rsv_addr != 0) mbusy[rsv_addr] = 1'b1;
    if (flush) mbusy = '0;
    @(posedge clock); #1;
  endtask

  task automatic chk_ports(input string tag);
    #1;
    chk({tag, "_da"}, rd_data_a, ref_rd(rd_addr_a));
    chk({tag, "_db"}, rd_data_b, ref_rd(rd_addr_b));
    chk({tag, "_ba"}, 32'(rd_busy_a), 32'(ref_busy(rd_addr_a)));
    chk({tag, "_bb"}, 32'(rd_busy_b), 32'(ref_busy(rd_addr_b)));
  endtask

  initial begin
    reset_n = 0; idle(); rd_addr_a = 29; rd_addr_b = 0;
    #2;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_busy", 32'({rd_busy_a, rd_busy_b}), 0);
    chk("rst_data", rd_data_a | rd_data_b, 0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset_n = 1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clock); #1;
      chk($sformatf("init_ready_e%0d", e), 32'(ready), 32'(e == 32));
      if (e == 31) chk("init_rd_zero", rd_data_a, 0);
    end
    model_init();

    for (int k = 0; k < 32; k++) begin
      rd_addr_a = 5'(k); rd_addr_b = 5'(31 - k); #1;
      chk($sformatf("initval_%0d", k), rd_data_a, (k == 0) ? 32'd0 : (k == 29) ? 32'h00008000 : 32'(k));
    end

    // Bypass then persistence
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_addr_a = 5; #1;
    chk("byp_same", rd_data_a, 32'hDEADBEEF);
    cyc(); idle(); #1;
    chk("byp_after", rd_data_a, 32'hDEADBEEF);

    // Zero register
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; rd_addr_a = 0; #1;
    chk("zero_byp", rd_data_a, 0);
    cyc(); idle(); #1;
    chk("zero_after", rd_data_a, 0);
    rsv_en = 1; rsv_addr = 0; cyc(); idle(); rd_addr_b = 0; #1;
    chk("zero_busy", 32'(rd_busy_b), 0);

    // Scoreboard on 7
    rsv_en = 1; rsv_addr = 7; cyc(); idle(); rd_addr_a = 7; #1;
    chk("b7_set", 32'(rd_busy_a), 1);
    wr_en = 1; wr_addr = 7; wr_data = 32'h77; #1;
    chk("b7_wrhide", 32'(rd_busy_a), 0);
    cyc(); idle(); #1;
    chk("b7_clr", 32'(rd_busy_a), 0);
    chk("b7_data", rd_data_a, 32'h77);

    // Same-edge reserve and write on 9
    rsv_en = 1; rsv_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h99;
    cyc(); idle(); rd_addr_a = 9; #1;
    chk("b9_setwins", 32'(rd_busy_a), 1);
    chk("b9_data", rd_data_a, 32'h99);

    // Flush beats a same-edge reserve
    rsv_en = 1; rsv_addr = 3; cyc(); rsv_addr = 4; cyc(); rsv_addr = 6; cyc(); idle();
    rd_addr_a = 3; rd_addr_b = 6; #1;
    chk("fl_pre3", 32'(rd_busy_a), 1);
    chk("fl_pre6", 32'(rd_busy_b), 1);
    flush = 1; rsv_en = 1; rsv_addr = 8; cyc(); idle();
    rd_addr_a = 3; rd_addr_b = 4; #1;
    chk("fl_3", 32'(rd_busy_a), 0);
    chk("fl_4", 32'(rd_busy_b), 0);
    rd_addr_a = 6; rd_addr_b = 8; #1;
    chk("fl_6", 32'(rd_busy_a), 0);
    chk("fl_8", 32'(rd_busy_b), 0);
    chk("fl_9", 32'(mbusy[9]), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      rsv_en    = ($urandom_range(0, 1) == 1);
      rsv_addr  = 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 15) == 0);
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rsv_addr : 5'($urandom_range(0, 31));
      chk_ports($sformatf("rnd%0d", i));
      cyc();
    end
    idle();

    // Reset mid-RUN, with traffic driven during INIT
    wr_en = 1; wr_addr = 10; wr_data = 32'hAAAA; cyc(); idle();
    rsv_en = 1; rsv_addr = 11; cyc(); idle();
    rd_addr_a = 11; rd_addr_b = 10; #1;
    chk("mr_pre_busy", 32'(rd_busy_a), 1);
    chk("mr_pre_data", rd_data_b, 32'hAAAA);
    reset_n = 0; #1;
    chk("mr_ready", 32'(ready), 0);
    chk("mr_busy", 32'(rd_busy_a), 0);
    chk("mr_data", rd_data_b, 0);
    @(negedge clock); reset_n = 1;
    wr_en = 1; wr_addr = 10; wr_data = 32'hFFFF; rsv_en = 1; rsv_addr = 10; flush = 0;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clock); #1;
      if (e == 32) idle();
      if (e == 1 || e == 31 || e == 32)
        chk($sformatf("mr_ready_e%0d", e), 32'(ready), 32'(e == 32));
    end
    model_init();
    rd_addr_a = 10; rd_addr_b = 10; #1;
    chk("mr_e10", rd_data_a, 32'd10);
    chk("mr_b10", 32'(rd_busy_b), 0);
    rd_addr_a = 29; rd_addr_b = 11; #1;
    chk("mr_sp", rd_data_a, 32'h00008000);
    chk("mr_b11", 32'(rd_busy_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
